// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : 32 x 32-bit general-purpose register file for the five-stage
//                pipeline. One write port fed by write-back and two
//                combinational read ports serving decode. Register 0 is
//                hard-wired to zero. A free-running counter tallies accepted
//                writes for debug.
//
//  Ports
//    clk     in   1   system clock, all state updates on the rising edge
//    rst     in   1   synchronous active-high reset
//    we      in   1   write enable from write-back
//    waddr   in   5   write register address
//    wdata   in   32  write data
//    re1     in   1   read port 1 enable
//    raddr1  in   5   read port 1 address
//    rdata1  out  32  read port 1 data (combinational)
//    re2     in   1   read port 2 enable
//    raddr2  in   5   read port 2 address
//    rdata2  out  32  read port 2 data (combinational)
//    wr_cnt  out  32  number of accepted writes (registered, wraps silently)
//
//  Build option
//    REGFILE_BYPASS_EN : when defined, a write presented in the current cycle
//                        is forwarded to any read port addressing the same
//                        register. When undefined, reads return the stored
//                        value and the new data is visible one cycle later.
//
//  Revision    : 1.0  initial release
// ============================================================================
module regfile #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re1,
    input  logic [4:0]       raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic             re2,
    input  logic [4:0]       raddr2,
    output logic [WIDTH-1:0] rdata2,
    output logic [31:0]      wr_cnt
);

    localparam int         c_AW     = 5;
    localparam int         c_NPORTS = 2;
    localparam logic [c_AW-1:0] c_ZERO_ADDR = '0;

    // ------------------------------------------------------------------------
    // Storage and debug counter
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [31:0]      r_wr_cnt;

    // A write to r0 is dropped entirely: nothing stored, nothing counted.
    logic w_wr_accept;
    assign w_wr_accept = we && (waddr != c_ZERO_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_cnt <= '0;
        end else if (w_wr_accept) begin
            r_mem[waddr] <= wdata;
            r_wr_cnt     <= r_wr_cnt + 32'd1;
        end
    end

    assign wr_cnt = r_wr_cnt;

    // ------------------------------------------------------------------------
    // Read ports: both ports share identical logic, so they are built from a
    // labelled generate loop over port-indexed views of the inputs.
    // ------------------------------------------------------------------------
    logic [c_NPORTS-1:0] w_re;
    logic [c_AW-1:0]     w_raddr [c_NPORTS];
    logic [WIDTH-1:0]    w_rdata [c_NPORTS];

    assign w_re[0]    = re1;
    assign w_re[1]    = re2;
    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    genvar p;
    generate
        for (p = 0; p < c_NPORTS; p++) begin : g_rd
            // Priority: reset, disabled port, r0, bypass (if built), array.
            always_comb begin
                w_rdata[p] = '0;
                if (rst) begin
                    w_rdata[p] = '0;
                end else if (!w_re[p]) begin
                    w_rdata[p] = '0;
                end else if (w_raddr[p] == c_ZERO_ADDR) begin
                    w_rdata[p] = '0;
`ifdef REGFILE_BYPASS_EN
                end else if (we && (waddr == w_raddr[p])) begin
                    // Same-cycle forward closes the WB->ID hazard.
                    w_rdata[p] = wdata;
`endif
                end else begin
                    w_rdata[p] = r_mem[w_raddr[p]];
                end
            end
        end
    endgenerate

    assign rdata1 = w_rdata[0];
    assign rdata2 = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile
//  Description : Self-checking bench for regfile. A table of single-cycle
//                vectors covers basic write/read, r0 handling and read-enable
//                gating; hand-written sequences cover reset, the same-cycle
//                bypass case and counter wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] wr_cnt;

    int total;
    int bad;

    regfile #(
        .DEPTH (32),
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] expcnt;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs are applied just after the falling edge, so they are stable
    // well before the next rising edge and checks happen mid-cycle.
    task automatic drive(input logic i_we, input logic [4:0] i_wa, input logic [31:0] i_wd,
                         input logic i_re1, input logic [4:0] i_ra1,
                         input logic i_re2, input logic [4:0] i_ra2);
        @(negedge clk);
        we     = i_we;
        waddr  = i_wa;
        wdata  = i_wd;
        re1    = i_re1;
        raddr1 = i_ra1;
        re2    = i_re2;
        raddr2 = i_ra2;
        #1;
    endtask

    logic [31:0] exp_byp;

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        re1    = 1'b0;
        raddr1 = '0;
        re2    = 1'b0;
        raddr2 = '0;

        // ---------------- reset behaviour ----------------
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        rst = 1'b0;
        chk("reset_cnt", wr_cnt, 32'h0);
        chk("reset_r5_p1", rdata1, 32'h0);

        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        chk("pre_rst_r5", rdata1, 32'hDEAD_BEEF);
        chk("pre_rst_cnt", wr_cnt, 32'h1);

        // Reset cycle with a write presented: read is forced to 0 and the
        // write to r6 must be discarded.
        @(negedge clk);
        rst = 1'b1;
        we = 1'b1; waddr = 5'd6; wdata = 32'h0000_0066;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd6;
        #1;
        chk("in_rst_rd1", rdata1, 32'h0);
        chk("in_rst_rd2", rdata2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        we = 1'b0;
        #1;
        chk("post_rst_r5", rdata1, 32'h0);
        chk("post_rst_r6", rdata2, 32'h0);
        chk("post_rst_cnt", wr_cnt, 32'h0);

        // ---------------- table vectors ----------------
        //                we    wa     wdata          re1   ra1    re2   ra2    exp1           exp2           cnt
        vecs[0]  = '{1'b1, 5'd7,  32'h1234_5678, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         32'h0,         32'd0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd0,  32'h1234_5678, 32'h0,         32'd1};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,         32'h0,         32'd1};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b1, 5'd7,  32'h0,         32'h1234_5678, 32'd1};
        vecs[4]  = '{1'b1, 5'd9,  32'hA5A5_A5A5, 1'b1, 5'd7,  1'b0, 5'd9,  32'h1234_5678, 32'h0,         32'd1};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd9,  1'b0, 5'd9,  32'h0,         32'h0,         32'd2};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  1'b1, 5'd9,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd2};
        vecs[7]  = '{1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd9,  1'b1, 5'd7,  32'hA5A5_A5A5, 32'h1234_5678, 32'd2};
        vecs[8]  = '{1'b1, 5'd1,  32'h0000_0001, 1'b1, 5'd31, 1'b1, 5'd0,  32'hCAFE_F00D, 32'h0,         32'd3};
        vecs[9]  = '{1'b1, 5'd7,  32'h7777_7777, 1'b1, 5'd1,  1'b1, 5'd31, 32'h0000_0001, 32'hCAFE_F00D, 32'd4};
        vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd1,  32'h7777_7777, 32'h0000_0001, 32'd5};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
            chk($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
            chk($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
            chk($sformatf("vec%0d_cnt", i), wr_cnt, vecs[i].expcnt);
        end

        // ---------------- same-cycle write/read of r3 ----------------
        drive(1'b1, 5'd3, 32'h0000_0011, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b1, 5'd3, 32'h0000_0022, 1'b1, 5'd3, 1'b1, 5'd3);
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h0000_0022;
`else
        exp_byp = 32'h0000_0011;
`endif
        chk("byp_same_rd1", rdata1, exp_byp);
        chk("byp_same_rd2", rdata2, exp_byp);
        chk("byp_same_cnt", wr_cnt, 32'd6);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
        chk("byp_next_rd1", rdata1, 32'h0000_0022);
        chk("byp_next_rd2", rdata2, 32'h0000_0022);
        chk("byp_next_cnt", wr_cnt, 32'd7);

        // ---------------- counter wrap ----------------
        @(negedge clk);
        force dut.r_wr_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_wr_cnt;
        #1;
        chk("wrap_preset", wr_cnt, 32'hFFFF_FFFE);
        drive(1'b1, 5'd2, 32'h0000_0002, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd2, 1'b0, 5'd0);
        chk("wrap_ffff", wr_cnt, 32'hFFFF_FFFF);
        chk("wrap_r2", rdata1, 32'h0000_0002);
        drive(1'b1, 5'd4, 32'h0000_0004, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("wrap_rej_r0", wr_cnt, 32'hFFFF_FFFF);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd0);
        chk("wrap_zero", wr_cnt, 32'h0);
        chk("wrap_r4", rdata1, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
